// File: rtl/game_pkg.sv
// Shared types for the two-player battleship turn controller: cell codes, game phases,
// controller states and board geometry.
package game_pkg;

  localparam int unsigned BOARD_DIM = 10;

  typedef enum logic [1:0] {
    CellEmpty = 2'b00,
    CellShip  = 2'b01,
    CellHit   = 2'b10,
    CellMiss  = 2'b11
  } cell_e;

  typedef enum logic [1:0] {
    PhIdle   = 2'b00,
    PhPlace  = 2'b01,
    PhBattle = 2'b10,
    PhOver   = 2'b11
  } phase_e;

  typedef enum logic [2:0] {
    StIdle,
    StPlace,
    StPRead,
    StPEval,
    StShoot,
    StSRead,
    StSEval,
    StOver
  } state_e;

  localparam logic [1:0] WinNone  = 2'b00;
  localparam logic [1:0] WinHost  = 2'b01;
  localparam logic [1:0] WinGuest = 2'b10;

  function automatic phase_e phase_of(state_e st);
    phase_e ph;
    ph = PhIdle;
    unique case (st)
      StPlace, StPRead, StPEval: ph = PhPlace;
      StShoot, StSRead, StSEval: ph = PhBattle;
      StOver:                    ph = PhOver;
      default:                   ph = PhIdle;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/game_turn_ctrl_if.sv
// Player-input, board-access and status bundle of the turn controller.
// master = controller side, slave = player/board environment side.
interface game_turn_ctrl_if;
  logic       start;
  logic       click;
  logic [3:0] cell_row;
  logic [3:0] cell_col;

  logic       rd_en;
  logic       rd_side;
  logic [6:0] rd_addr;
  logic [1:0] rd_data;

  logic       wr_en;
  logic       wr_side;
  logic [6:0] wr_addr;
  logic [1:0] wr_data;

  logic [1:0] phase;
  logic       turn;
  logic [2:0] hits_host;
  logic [2:0] hits_guest;
  logic [1:0] winner;

  modport master (
    input  start, click, cell_row, cell_col, rd_data,
    output rd_en, rd_side, rd_addr, wr_en, wr_side, wr_addr, wr_data,
    output phase, turn, hits_host, hits_guest, winner
  );

  modport slave (
    output start, click, cell_row, cell_col, rd_data,
    input  rd_en, rd_side, rd_addr, wr_en, wr_side, wr_addr, wr_data,
    input  phase, turn, hits_host, hits_guest, winner
  );
endinterface

// File: rtl/game_addr_map.sv
// Maps a (row, col) board coordinate to a linear cell address row*BOARD_DIM+col and
// flags whether the coordinate lies on the board.
module game_addr_map
  import game_pkg::*;
(
  input  logic [3:0] row_i,
  input  logic [3:0] col_i,
  output logic [6:0] addr_o,
  output logic       valid_o
);

  localparam logic [3:0] Dim = 4'(BOARD_DIM);

  always_comb begin
    valid_o = (row_i < Dim) && (col_i < Dim);
    // Out-of-range coordinates may wrap; callers gate on valid_o.
    addr_o  = 7'(row_i) * 7'(BOARD_DIM) + 7'(col_i);
  end

endmodule

// File: rtl/game_turn_ctrl.sv
// Turn controller for a two-player battleship game: ship placement, alternating shots
// with extra shot on a hit, hit counting and win detection. All outputs are registered.
module game_turn_ctrl
  import game_pkg::*;
#(
  parameter int unsigned SHIP_CELLS = 4
) (
  input logic              clk,
  input logic              rst,
  game_turn_ctrl_if.master bus_io
);

  localparam logic [2:0] ShipCnt = 3'(SHIP_CELLS);

  logic [6:0] map_addr;
  logic       map_valid;

  game_addr_map u_addr_map (
    .row_i   (bus_io.cell_row),
    .col_i   (bus_io.cell_col),
    .addr_o  (map_addr),
    .valid_o (map_valid)
  );

  state_e     state_q, state_d;
  phase_e     phase_q, phase_d;
  logic       turn_q, turn_d;
  logic [2:0] place_cnt_q, place_cnt_d;
  logic [2:0] hits_host_q, hits_host_d;
  logic [2:0] hits_guest_q, hits_guest_d;
  logic [1:0] winner_q, winner_d;
  logic       rd_en_q, rd_en_d;
  logic       rd_side_q, rd_side_d;
  logic [6:0] rd_addr_q, rd_addr_d;
  logic       wr_en_q, wr_en_d;
  logic       wr_side_q, wr_side_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [1:0] wr_data_q, wr_data_d;

  cell_e      rd_cell;
  logic [2:0] shooter_hits;
  logic [2:0] shooter_hits_inc;

  assign rd_cell          = cell_e'(bus_io.rd_data);
  assign shooter_hits     = turn_q ? hits_guest_q : hits_host_q;
  assign shooter_hits_inc = (shooter_hits < ShipCnt) ? shooter_hits + 3'd1 : shooter_hits;

  always_comb begin
    state_d      = state_q;
    turn_d       = turn_q;
    place_cnt_d  = place_cnt_q;
    hits_host_d  = hits_host_q;
    hits_guest_d = hits_guest_q;
    winner_d     = winner_q;
    rd_en_d      = 1'b0;
    rd_side_d    = rd_side_q;
    rd_addr_d    = rd_addr_q;
    wr_en_d      = 1'b0;
    wr_side_d    = wr_side_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    unique case (state_q)
      StIdle, StOver: begin
        if (bus_io.start) begin
          state_d      = StPlace;
          turn_d       = 1'b0;
          place_cnt_d  = '0;
          hits_host_d  = '0;
          hits_guest_d = '0;
          winner_d     = WinNone;
        end
      end
      StPlace, StShoot: begin
        if (bus_io.click && map_valid) begin
          rd_en_d   = 1'b1;
          rd_addr_d = map_addr;
          // Placement works on the own board, shooting on the opponent's.
          if (state_q == StPlace) begin
            state_d   = StPRead;
            rd_side_d = turn_q;
          end else begin
            state_d   = StSRead;
            rd_side_d = ~turn_q;
          end
        end
      end
      StPRead: state_d = StPEval;
      StSRead: state_d = StSEval;
      StPEval: begin
        state_d = StPlace;
        if (rd_cell == CellEmpty) begin
          wr_en_d     = 1'b1;
          wr_side_d   = rd_side_q;
          wr_addr_d   = rd_addr_q;
          wr_data_d   = CellShip;
          place_cnt_d = place_cnt_q + 3'd1;
          if (place_cnt_q + 3'd1 == ShipCnt) begin
            place_cnt_d = '0;
            turn_d      = ~turn_q;
            if (turn_q) state_d = StShoot;
          end
        end
      end
      StSEval: begin
        state_d   = StShoot;
        wr_side_d = rd_side_q;
        wr_addr_d = rd_addr_q;
        unique case (rd_cell)
          CellShip: begin
            wr_en_d   = 1'b1;
            wr_data_d = CellHit;
            if (turn_q) hits_guest_d = shooter_hits_inc;
            else        hits_host_d  = shooter_hits_inc;
            if (shooter_hits_inc == ShipCnt) begin
              state_d  = StOver;
              winner_d = turn_q ? WinGuest : WinHost;
            end
          end
          CellEmpty: begin
            wr_en_d   = 1'b1;
            wr_data_d = CellMiss;
            turn_d    = ~turn_q;
          end
          default: ;
        endcase
      end
      default: state_d = StIdle;
    endcase

    phase_d = phase_of(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      phase_q      <= PhIdle;
      turn_q       <= 1'b0;
      place_cnt_q  <= '0;
      hits_host_q  <= '0;
      hits_guest_q <= '0;
      winner_q     <= WinNone;
      rd_en_q      <= 1'b0;
      rd_side_q    <= 1'b0;
      rd_addr_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_side_q    <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      turn_q       <= turn_d;
      place_cnt_q  <= place_cnt_d;
      hits_host_q  <= hits_host_d;
      hits_guest_q <= hits_guest_d;
      winner_q     <= winner_d;
      rd_en_q      <= rd_en_d;
      rd_side_q    <= rd_side_d;
      rd_addr_q    <= rd_addr_d;
      wr_en_q      <= wr_en_d;
      wr_side_q    <= wr_side_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign bus_io.rd_en      = rd_en_q;
  assign bus_io.rd_side    = rd_side_q;
  assign bus_io.rd_addr    = rd_addr_q;
  assign bus_io.wr_en      = wr_en_q;
  assign bus_io.wr_side    = wr_side_q;
  assign bus_io.wr_addr    = wr_addr_q;
  assign bus_io.wr_data    = wr_data_q;
  assign bus_io.phase      = phase_q;
  assign bus_io.turn       = turn_q;
  assign bus_io.hits_host  = hits_host_q;
  assign bus_io.hits_guest = hits_guest_q;
  assign bus_io.winner     = winner_q;

endmodule

// File: tb/tb_game_turn_ctrl.sv
// Bench for game_turn_ctrl: directed vector table, hand-written corner sequences and
// random clicks checked against a transaction-level game model.
module tb_game_turn_ctrl;

  localparam int Ship = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  game_turn_ctrl_if bus ();

  game_turn_ctrl #(.SHIP_CELLS(Ship)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int n_overlap = 0;

  // Board memory seen by the DUT: one-cycle read latency, write on the edge.
  logic [1:0] board [2][100];
  bit clr_req;
  always @(posedge clk) begin
    if (clr_req) begin
      for (int s = 0; s < 2; s++)
        for (int a = 0; a < 100; a++) board[s][a] <= 2'b00;
    end else if (bus.wr_en && int'(bus.wr_addr) < 100) begin
      board[int'(bus.wr_side)][int'(bus.wr_addr)] <= bus.wr_data;
    end
    bus.rd_data <= (bus.rd_en && int'(bus.rd_addr) < 100) ?
                   board[int'(bus.rd_side)][int'(bus.rd_addr)] : 2'b00;
    if (bus.rd_en && bus.wr_en) n_overlap <= n_overlap + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Game model: phase 0 idle, 1 place, 2 battle, 3 over; cells 0 empty 1 ship 2 hit 3 miss.
  int m_phase, m_turn, m_cnt, m_winner;
  int m_hits [2];
  int m_board [2][100];
  int e_acc, e_wr, e_side, e_addr, e_data;

  task automatic model_reset();
    m_phase = 0; m_turn = 0; m_cnt = 0; m_winner = 0;
    m_hits[0] = 0; m_hits[1] = 0;
  endtask

  task automatic model_start();
    if (m_phase == 0 || m_phase == 3) begin
      m_phase = 1; m_turn = 0; m_cnt = 0; m_winner = 0;
      m_hits[0] = 0; m_hits[1] = 0;
    end
  endtask

  task automatic model_click(input int r, input int c);
    int a, side;
    e_acc = 0; e_wr = 0; e_side = 0; e_addr = 0; e_data = 0;
    if ((m_phase == 1 || m_phase == 2) && r < 10 && c < 10) begin
      a = r * 10 + c;
      e_acc = 1; e_addr = a;
      if (m_phase == 1) begin
        side = m_turn; e_side = side;
        if (m_board[side][a] == 0) begin
          m_board[side][a] = 1; e_wr = 1; e_data = 1;
          m_cnt++;
          if (m_cnt == Ship) begin
            m_cnt = 0;
            if (m_turn == 1) m_phase = 2;
            m_turn = 1 - m_turn;
          end
        end
      end else begin
        side = 1 - m_turn; e_side = side;
        if (m_board[side][a] == 1) begin
          m_board[side][a] = 2; e_wr = 1; e_data = 2;
          if (m_hits[m_turn] < Ship) m_hits[m_turn]++;
          if (m_hits[m_turn] == Ship) begin
            m_phase = 3; m_winner = m_turn + 1;
          end
        end else if (m_board[side][a] == 0) begin
          m_board[side][a] = 3; e_wr = 1; e_data = 3;
          m_turn = 1 - m_turn;
        end
      end
    end
  endtask

  // Observations of one click transaction: read cycle N+1, write/status cycle N+3.
  int o_rd, o_rd_side, o_rd_addr, o_wr, o_wr_side, o_wr_addr, o_wr_data;
  int o_phase, o_turn, o_hh, o_hg, o_win;

  task automatic click_txn(input int r, input int c);
    @(negedge clk);
    bus.click = 1'b1; bus.cell_row = 4'(r); bus.cell_col = 4'(c);
    @(negedge clk);
    bus.click = 1'b0;
    o_rd = int'(bus.rd_en); o_rd_side = int'(bus.rd_side); o_rd_addr = int'(bus.rd_addr);
    @(negedge clk);
    @(negedge clk);
    o_wr = int'(bus.wr_en); o_wr_side = int'(bus.wr_side);
    o_wr_addr = int'(bus.wr_addr); o_wr_data = int'(bus.wr_data);
    o_phase = int'(bus.phase); o_turn = int'(bus.turn);
    o_hh = int'(bus.hits_host); o_hg = int'(bus.hits_guest); o_win = int'(bus.winner);
  endtask

  task automatic check_status(input string tag);
    chk({tag, " phase"}, int'(bus.phase), m_phase);
    chk({tag, " turn"}, int'(bus.turn), m_turn);
    chk({tag, " hits_host"}, int'(bus.hits_host), m_hits[0]);
    chk({tag, " hits_guest"}, int'(bus.hits_guest), m_hits[1]);
    chk({tag, " winner"}, int'(bus.winner), m_winner);
  endtask

  task automatic do_click(input int r, input int c);
    string tag;
    tag = $sformatf("click(%0d,%0d)", r, c);
    model_click(r, c);
    click_txn(r, c);
    chk({tag, " rd_en"}, o_rd, e_acc);
    if (e_acc != 0) begin
      chk({tag, " rd_side"}, o_rd_side, e_side);
      chk({tag, " rd_addr"}, o_rd_addr, e_addr);
    end
    chk({tag, " wr_en"}, o_wr, e_wr);
    if (e_wr != 0) begin
      chk({tag, " wr_side"}, o_wr_side, e_side);
      chk({tag, " wr_addr"}, o_wr_addr, e_addr);
      chk({tag, " wr_data"}, o_wr_data, e_data);
    end
    check_status(tag);
  endtask

  task automatic do_start();
    model_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    check_status("start");
  endtask

  task automatic clear_boards();
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 100; a++) m_board[s][a] = 0;
    @(negedge clk); clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
  endtask

  typedef struct {
    int row, col, rd, wr, side, addr, data, phase, turn, hh, hg;
  } vec_t;

  function automatic vec_t mk(int row, int col, int rd, int wr, int side, int addr, int data,
                              int phase, int turn, int hh, int hg);
    vec_t v;
    v.row = row; v.col = col; v.rd = rd; v.wr = wr; v.side = side; v.addr = addr;
    v.data = data; v.phase = phase; v.turn = turn; v.hh = hh; v.hg = hg;
    return v;
  endfunction

  vec_t vecs [15];

  initial begin
    //            row col rd wr side addr data ph turn hh hg
    vecs[0]  = mk(0,  0,  1, 1, 0,   0,   1,   1, 0,   0, 0);
    vecs[1]  = mk(0,  1,  1, 1, 0,   1,   1,   1, 0,   0, 0);
    vecs[2]  = mk(0,  2,  1, 1, 0,   2,   1,   1, 0,   0, 0);
    vecs[3]  = mk(0,  3,  1, 1, 0,   3,   1,   1, 1,   0, 0);
    vecs[4]  = mk(0,  0,  1, 1, 1,   0,   1,   1, 1,   0, 0);
    vecs[5]  = mk(0,  0,  1, 0, 1,   0,   0,   1, 1,   0, 0);
    vecs[6]  = mk(10, 3,  0, 0, 0,   0,   0,   1, 1,   0, 0);
    vecs[7]  = mk(4,  5,  1, 1, 1,   45,  1,   1, 1,   0, 0);
    vecs[8]  = mk(9,  9,  1, 1, 1,   99,  1,   1, 1,   0, 0);
    vecs[9]  = mk(5,  5,  1, 1, 1,   55,  1,   2, 0,   0, 0);
    vecs[10] = mk(4,  5,  1, 1, 1,   45,  2,   2, 0,   1, 0);
    vecs[11] = mk(1,  1,  1, 1, 1,   11,  3,   2, 1,   1, 0);
    vecs[12] = mk(0,  0,  1, 1, 0,   0,   2,   2, 1,   1, 1);
    vecs[13] = mk(0,  0,  1, 0, 0,   0,   0,   2, 1,   1, 1);
    vecs[14] = mk(7,  7,  1, 1, 0,   77,  3,   2, 0,   1, 1);

    rst = 1'b1; clr_req = 1'b1;
    bus.start = 1'b0; bus.click = 1'b0; bus.cell_row = '0; bus.cell_col = '0;
    model_reset();
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 100; a++) m_board[s][a] = 0;
    repeat (3) @(negedge clk);
    chk("reset phase", int'(bus.phase), 0);
    chk("reset turn", int'(bus.turn), 0);
    chk("reset hits_host", int'(bus.hits_host), 0);
    chk("reset hits_guest", int'(bus.hits_guest), 0);
    chk("reset winner", int'(bus.winner), 0);
    chk("reset rd_en", int'(bus.rd_en), 0);
    chk("reset wr_en", int'(bus.wr_en), 0);
    chk("reset rd_addr", int'(bus.rd_addr), 0);
    chk("reset wr_data", int'(bus.wr_data), 0);
    rst = 1'b0; clr_req = 1'b0;

    do_click(2, 2);   // idle: dropped
    do_start();

    for (int i = 0; i < 15; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      model_click(vecs[i].row, vecs[i].col);
      click_txn(vecs[i].row, vecs[i].col);
      chk({tag, " rd_en"}, o_rd, vecs[i].rd);
      if (vecs[i].rd != 0) begin
        chk({tag, " rd_side"}, o_rd_side, vecs[i].side);
        chk({tag, " rd_addr"}, o_rd_addr, vecs[i].addr);
      end
      chk({tag, " wr_en"}, o_wr, vecs[i].wr);
      if (vecs[i].wr != 0) begin
        chk({tag, " wr_side"}, o_wr_side, vecs[i].side);
        chk({tag, " wr_addr"}, o_wr_addr, vecs[i].addr);
        chk({tag, " wr_data"}, o_wr_data, vecs[i].data);
      end
      chk({tag, " phase"}, o_phase, vecs[i].phase);
      chk({tag, " turn"}, o_turn, vecs[i].turn);
      chk({tag, " hits_host"}, o_hh, vecs[i].hh);
      chk({tag, " hits_guest"}, o_hg, vecs[i].hg);
    end

    // Host hits (9,9); a second click held during S_READ must be dropped.
    model_click(9, 9);
    @(negedge clk); bus.click = 1'b1; bus.cell_row = 4'd9; bus.cell_col = 4'd9;
    @(negedge clk); bus.cell_row = 4'd5; bus.cell_col = 4'd5;
    chk("sread rd_en", int'(bus.rd_en), 1);
    chk("sread rd_addr", int'(bus.rd_addr), 99);
    @(negedge clk); bus.click = 1'b0;
    chk("sread drop rd_en", int'(bus.rd_en), 0);
    @(negedge clk);
    chk("sread wr_en", int'(bus.wr_en), 1);
    chk("sread wr_addr", int'(bus.wr_addr), 99);
    chk("sread wr_data", int'(bus.wr_data), 2);
    repeat (2) @(negedge clk);
    chk("sread later rd_en", int'(bus.rd_en), 0);
    check_status("sread after");

    do_click(5, 5);
    do_click(0, 0);   // fourth host hit
    chk("over phase in write cycle", o_phase, 3);
    chk("over winner in write cycle", o_win, 1);
    chk("over wr_en", o_wr, 1);
    do_click(1, 2);   // ignored after game over
    do_start();
    chk("restart phase", int'(bus.phase), 1);
    chk("restart hits_host", int'(bus.hits_host), 0);

    // Reset while a shot is in S_EVAL must abort the write.
    clear_boards();
    for (int i = 0; i < 4; i++) do_click(0, i);
    for (int i = 0; i < 4; i++) do_click(1, i);
    @(negedge clk); bus.click = 1'b1; bus.cell_row = 4'd1; bus.cell_col = 4'd0;
    @(negedge clk); bus.click = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("rst eval wr_en", int'(bus.wr_en), 0);
    chk("rst eval phase", int'(bus.phase), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post rst wr_en %0d", i), int'(bus.wr_en), 0);
    end
    chk("rst abort board cell", int'(board[1][10]), 1);
    model_reset();
    check_status("post rst");

    clear_boards();
    do_start();
    for (int i = 0; i < 400; i++) begin
      int r, c;
      if (m_phase == 3 || m_phase == 0) begin
        clear_boards();
        do_start();
      end else if ($urandom_range(0, 19) == 0) begin
        do_start();
      end else begin
        r = ($urandom_range(0, 15) == 0) ? 10 + int'($urandom_range(0, 5))
                                         : int'($urandom_range(0, 4));
        c = ($urandom_range(0, 15) == 0) ? 10 + int'($urandom_range(0, 5))
                                         : int'($urandom_range(0, 4));
        do_click(r, c);
      end
    end

    chk("rd_en and wr_en overlap", n_overlap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/game_turn_ctrl.md
GAME_TURN_CTRL -- requirements
Module: game_turn_ctrl

Interface
REQ-001 SHIP_CELLS, 4, ship cells each player places; sets the hit count that wins.
REQ-002 clk  in  1  system clock; all logic is on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  one-cycle pulse; begins or restarts a game.
REQ-005 click  in  1  one-cycle pulse; a player selected a cell.
REQ-006 cell_row, cell_col  in  4 each  selected cell; valid range 0..9.
REQ-007 rd_en, rd_side, rd_addr  out  1/1/7  board read request; side 0=host, 1=guest; addr=row*10+col.
REQ-008 rd_data  in  2  cell code returned by the board one cycle after rd_en.
REQ-009 wr_en, wr_side, wr_addr, wr_data  out  1/1/7/2  one-cycle board write.
REQ-010 phase  out  2  game phase: 00 idle, 01 place, 10 battle, 11 over.
REQ-011 turn  out  1  active player: 0 host, 1 guest.
REQ-012 hits_host, hits_guest  out  3 each  hits scored by each player.
REQ-013 winner  out  2  game result: 00 none, 01 host, 10 guest.

Function
REQ-014 Cell codes SHALL be: 00 empty, 01 ship, 10 hit, 11 miss.
REQ-015 FSM states SHALL be IDLE, PLACE, P_READ, P_EVAL, SHOOT, S_READ, S_EVAL, OVER; all outputs are registered.
REQ-016 IDLE or OVER plus start SHALL go to PLACE with turn=0, place count=0, hits=0, winner=00; start is ignored in every other state.
REQ-017 A click SHALL be accepted only in PLACE or SHOOT, and only when row<=9 and col<=9; all other clicks are dropped without any side effect.
REQ-018 Accepted click in cycle N: rd_en SHALL be high for exactly cycle N+1 with the address and side latched; rd_data is sampled at the end of N+2 (EVAL); any write occurs in N+3; the FSM is back in PLACE or SHOOT in N+3.
REQ-019 PLACE: the read and write side SHALL be turn (own board); if rd_data=00, write 01 and increment the place count; otherwise make no write and no count change.
REQ-020 When the place count reaches SHIP_CELLS: if turn=0, set turn=1, clear the count and stay in PLACE; if turn=1, set turn=0 and go to SHOOT.
REQ-021 SHOOT: the read and write side SHALL be ~turn (opponent board).
REQ-022 SHOOT, rd_data=01: write 10 and increment the shooter's hits; turn is unchanged (extra shot).
REQ-023 SHOOT, rd_data=00: write 11 and toggle turn.
REQ-024 SHOOT, rd_data=10 or 11: no write and no turn change (repeat shot ignored).
REQ-025 When a hit brings the shooter's hits to SHIP_CELLS, the FSM SHALL enter OVER in the same cycle as the write, with winner set to the shooter; no further clicks are accepted.
REQ-026 phase SHALL be 01 in PLACE/P_READ/P_EVAL, 10 in SHOOT/S_READ/S_EVAL, 00 in IDLE and 11 in OVER.
REQ-027 A click arriving during READ or EVAL SHALL be dropped, not queued.
REQ-028 The hit counters SHALL saturate at SHIP_CELLS.
REQ-029 rd_en and wr_en SHALL never be high in the same cycle.

Reset
REQ-030 rst SHALL force IDLE, turn=0, counters=0, and clear phase, winner, rd_en, wr_en, rd_side, rd_addr, wr_side, wr_addr and wr_data to 0.
REQ-031 rst asserted mid-transaction SHALL abort it; no write is issued after rst is released.
REQ-032 This block SHALL NOT clear the boards; board clearing belongs to the board module's own reset.

Structure
REQ-033 The shared package game_pkg SHALL hold the cell-code enum, the phase enum, the FSM state enum and BOARD_DIM=10.
REQ-034 One combinational sub-module, game_addr_map, SHALL map (row, col) to a 7-bit address and a range-valid flag.

Verification
REQ-035 Reset then start; host clicks empty cells (0,0),(0,1),(0,2),(0,3) -> four wr side0 data01 at addr 0..3; turn=1, phase=01.
REQ-036 During guest placement, click (0,0) twice -> second rd_data=01 gives no write; place count stays 1.
REQ-037 In battle, host clicks a guest ship cell at addr 45 -> wr side1 addr45 data10, hits_host=1, turn stays 0; host then clicks an empty cell -> data11, turn=1.
REQ-038 Click (10,3) or a click during S_READ -> no rd_en, no state change.
REQ-039 Host scores a 4th hit -> phase=11, winner=01 in the write cycle; later clicks are ignored; start returns phase=01 with hits cleared.
REQ-040 rst asserted in S_EVAL -> no wr_en, phase=00 on the next edge.
